trap_sequencer: RTL and testbench
=================================

// Module: trap_sequencer
// PURPOSE
//  M-mode trap/return sequencer between the pipeline and the CSR file.
//  - Accepts synchronous exceptions, pending interrupts and mret; prioritises them.
//  - Drains the pipeline, then issues ordered single-cycle CSR writes (mepc, mcause, mtval, mstatus).
//  - Redirects fetch to the trap vector or mepc. M-only hart.
// PARAMETERS
//  Xlen  core_pkg::Xlen (64)  datapath / CSR width
// PORTS
//  clk_i            in   1     clock
//  rst_i            in   1     synchronous, active-high reset
//  exc_valid_i      in   1     exception pulse from commit (sampled only when busy_o=0)
//  exc_cause_i      in   Xlen  csr_mcause_e code, bit Xlen-1 = 0
//  exc_pc_i         in   Xlen  pc of faulting instruction
//  exc_tval_i       in   Xlen  mtval value for the exception
//  mret_valid_i     in   1     mret committing (sampled only when busy_o=0)
//  irq_pc_i         in   Xlen  pc of next instruction to commit (mepc for interrupts)
//  mip_i, mie_i     in   Xlen  current mip / mie CSR values
//  mstatus_i        in   Xlen  current mstatus (csr_mstatus_t layout)
//  mtvec_i, mepc_i  in   Xlen  current mtvec / mepc
//  flush_ready_i    in   1     pipeline reports drained
//  busy_o           out  1     sequence in progress; pipeline must not commit
//  flush_o          out  1     kill younger instructions
//  csr_we_o         out  1     CSR write strobe
//  csr_waddr_o      out  12    csr_addrs_e address
//  csr_wdata_o      out  Xlen  CSR write data
//  redirect_valid_o out  1     one-cycle fetch redirect
//  redirect_pc_o    out  Xlen  redirect target
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; latched cause/pc/tval/kind cleared. Reset mid-sequence
//   aborts immediately; partially written CSRs are left as-is.
//  Arbitration in IDLE, in priority order:
//   1. exc_valid_i
//   2. interrupt: mstatus_i.mie & |(mip_i&mie_i), priority MEI(11) > MSI(3) > MTI(7) > SEI(9)
//      > SSI(1) > STI(5) > LCOFI(13), mcause = {1'b1, code}
//   3. mret_valid_i
//  Exception + mret in the same cycle -> exception wins, mret dropped.
//  On acceptance, latch kind/cause/pc/tval (tval=0 for interrupts; pc=irq_pc_i for interrupts).
//   Inputs are ignored while busy_o=1.
//  busy_o = (state != IDLE). flush_o = (state == FLUSH).
//  Trap path:  IDLE -> FLUSH -> W_EPC -> W_CAUSE -> W_TVAL -> W_STATUS -> REDIRECT -> IDLE
//  mret path:  IDLE -> FLUSH -> W_STATUS -> REDIRECT -> IDLE
//  FLUSH holds while flush_ready_i=0 (unbounded). Every other state lasts exactly 1 cycle.
//  Write states: csr_we_o=1 with addr/data:
//   W_EPC    = CSRmepc,  {pc[Xlen-1:1],1'b0}
//   W_CAUSE  = CSRmcause, cause
//   W_TVAL   = CSRmtval,  tval
//   W_STATUS = CSRmstatus, mstatus_i with fields modified:
//     trap: mpie <= mie, mie <= 0, mpp <= 2'b11
//     mret: mie <= mpie, mpie <= 1, mpp <= 2'b11 (M-only)
//     All other bits pass through unchanged.
//  Outside write states: csr_we_o=0, csr_waddr_o=0, csr_wdata_o=0.
//  REDIRECT: redirect_valid_o=1 for one cycle; redirect_pc_o=0 in every other state.
//   trap target: {mtvec_i[Xlen-1:2],2'b00}
//   mret target: mepc_i sampled in REDIRECT (reflects CSR file state)
//  Latency with flush_ready_i=1 and acceptance at edge N:
//   trap: redirect_valid_o high during cycle N+6
//   mret: redirect_valid_o high during cycle N+3
//  New request may be accepted in the cycle after REDIRECT.
// CONFIGURATION
//  TRAP_VECTORED_EN defined:
//   - interrupt with mtvec_i[1:0]=2'b01 -> target = base + 4*cause[Xlen-2:0]
//   - exceptions and mode 2'b00 -> base
//   - modes 2'b1x treated as direct
//  TRAP_VECTORED_EN undefined: mtvec_i[1:0] ignored; all traps go to base.
// TESTING
//  1. exc IllegalInst, pc=0x8000_0010, tval=0x13, mtvec=0x8000_1000, mstatus.mie=1,
//     flush_ready=1 -> writes mepc=0x8000_0010, mcause=2, mtval=0x13, mstatus.mie=0/mpie=1/mpp=3;
//     redirect 0x8000_1000 at N+6.
//  2. mip=mie=0x888, mstatus.mie=1, irq_pc=0x8000_0200 -> mcause={1,63'd11},
//     mepc=0x8000_0200, mtval=0; with TRAP_VECTORED_EN and mtvec=0x8000_1001,
//     redirect 0x8000_102C.
//  3. mret, mstatus.mpie=1, mepc=0x8000_0040 -> single mstatus write (mie=1, mpie=1);
//     redirect 0x8000_0040 at N+3.
//  4. exc_valid_i and mret_valid_i in the same cycle, with an interrupt pending -> exception
//     sequence only; interrupt taken after return to IDLE only if mstatus.mie=1.
//  5. flush_ready_i held 0 for 5 cycles -> flush_o/busy_o high throughout, no CSR write;
//     sequence resumes on the cycle flush_ready_i rises.
//  6. rst_i asserted in W_CAUSE -> next cycle IDLE, all outputs 0, no redirect; new exception
//     accepted normally.

Source files
------------

// File: rtl/trap_sequencer.sv
// -----------------------------------------------------------------------------
// trap_sequencer
//
// M-mode trap/return sequencer that sits between the pipeline and the CSR file
// of an M-only hart.
//   - In IDLE it arbitrates between a synchronous exception, a pending and
//     enabled interrupt, and an mret. Exceptions win over interrupts, and
//     interrupts win over mret.
//   - It drains the pipeline (FLUSH). It then issues ordered single-cycle CSR
//     writes: mepc, mcause, mtval and mstatus for a trap, or mstatus alone for
//     an mret.
//   - It finishes with a one-cycle fetch redirect, to the trap vector for a
//     trap or to mepc for an mret.
//
// Optional feature (compile-time macro TRAP_VECTORED_EN):
//   When the macro is defined, an interrupt taken with mtvec mode 2'b01 jumps
//   to base + 4*code. All other cases (exceptions, mode 2'b00, modes 2'b1x)
//   jump to base. When the macro is undefined, mtvec[1:0] is ignored and every
//   trap jumps to base.
//
// Ports:
//   clk_i            clock
//   rst_i            synchronous, active-high reset
//   exc_valid_i      exception pulse from commit (sampled only when idle)
//   exc_cause_i      exception mcause code (interrupt bit = 0)
//   exc_pc_i         pc of the faulting instruction
//   exc_tval_i       mtval value for the exception
//   mret_valid_i     mret committing (sampled only when idle)
//   irq_pc_i         pc of the next instruction to commit (mepc for interrupts)
//   mip_i, mie_i     current mip / mie
//   mstatus_i        current mstatus
//   mtvec_i, mepc_i  current mtvec / mepc
//   flush_ready_i    pipeline reports drained
//   busy_o           sequence in progress; the pipeline must not commit
//   flush_o          kill younger instructions
//   csr_we_o         CSR write strobe
//   csr_waddr_o      CSR write address
//   csr_wdata_o      CSR write data
//   redirect_valid_o one-cycle fetch redirect
//   redirect_pc_o    redirect target
// -----------------------------------------------------------------------------
module trap_sequencer #(
    parameter int Xlen = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            exc_valid_i,
    input  logic [Xlen-1:0] exc_cause_i,
    input  logic [Xlen-1:0] exc_pc_i,
    input  logic [Xlen-1:0] exc_tval_i,
    input  logic            mret_valid_i,
    input  logic [Xlen-1:0] irq_pc_i,
    input  logic [Xlen-1:0] mip_i,
    input  logic [Xlen-1:0] mie_i,
    input  logic [Xlen-1:0] mstatus_i,
    input  logic [Xlen-1:0] mtvec_i,
    input  logic [Xlen-1:0] mepc_i,
    input  logic            flush_ready_i,
    output logic            busy_o,
    output logic            flush_o,
    output logic            csr_we_o,
    output logic [11:0]     csr_waddr_o,
    output logic [Xlen-1:0] csr_wdata_o,
    output logic            redirect_valid_o,
    output logic [Xlen-1:0] redirect_pc_o
);

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    // mstatus field positions
    localparam int MS_MIE  = 3;
    localparam int MS_MPIE = 7;
    localparam int MS_MPP  = 11;  // two bits: [12:11]

    // Interrupt codes, highest priority at index 0:
    // MEI > MSI > MTI > SEI > SSI > STI > LCOFI
    localparam int NUM_IRQ = 7;
    localparam logic [NUM_IRQ-1:0][3:0] IRQ_CODES =
        {4'd13, 4'd5, 4'd1, 4'd9, 4'd7, 4'd3, 4'd11};

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        W_EPC,
        W_CAUSE,
        W_TVAL,
        W_STATUS,
        REDIRECT
    } state_e;

    state_e            state_reg,  state_next;
    logic              mret_reg,   mret_next;   // 1: mret sequence, 0: trap
    logic [Xlen-1:0]   cause_reg,  cause_next;
    logic [Xlen-1:1]   pc_reg,     pc_next;     // mepc is always halfword aligned
    logic [Xlen-1:0]   tval_reg,   tval_next;

    // -------------------------------------------------------------------------
    // Interrupt selection
    // -------------------------------------------------------------------------
    logic [Xlen-1:0]    irq_pend;
    logic [NUM_IRQ-1:0] prio_pend;
    logic [3:0]         irq_code;
    logic               irq_take;

    assign irq_pend = mip_i & mie_i;

    // Only the standard M-visible interrupt lines are arbitrated. An
    // unrecognised pending bit has no defined cause code, so it cannot start
    // a trap.
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_prio
            assign prio_pend[gi] = irq_pend[IRQ_CODES[gi]];
        end
    endgenerate

    // Walk from the lowest priority to the highest so that the last hit wins.
    always_comb begin
        irq_code = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (prio_pend[i]) begin
                irq_code = IRQ_CODES[i];
            end
        end
    end

    assign irq_take = mstatus_i[MS_MIE] & (|prio_pend);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            mret_reg  <= 1'b0;
            cause_reg <= '0;
            pc_reg    <= '0;
            tval_reg  <= '0;
        end else begin
            state_reg <= state_next;
            mret_reg  <= mret_next;
            cause_reg <= cause_next;
            pc_reg    <= pc_next;
            tval_reg  <= tval_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and request latching
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        mret_next  = mret_reg;
        cause_next = cause_reg;
        pc_next    = pc_reg;
        tval_next  = tval_reg;

        unique case (state_reg)
            IDLE: begin
                if (exc_valid_i) begin
                    // A simultaneous mret is dropped: the exception belongs to
                    // an older or the same instruction.
                    state_next = FLUSH;
                    mret_next  = 1'b0;
                    cause_next = exc_cause_i;
                    pc_next    = exc_pc_i[Xlen-1:1];
                    tval_next  = exc_tval_i;
                end else if (irq_take) begin
                    state_next = FLUSH;
                    mret_next  = 1'b0;
                    cause_next = {1'b1, {(Xlen-5){1'b0}}, irq_code};
                    pc_next    = irq_pc_i[Xlen-1:1];
                    tval_next  = '0;
                end else if (mret_valid_i) begin
                    state_next = FLUSH;
                    mret_next  = 1'b1;
                    cause_next = '0;
                    pc_next    = '0;
                    tval_next  = '0;
                end
            end
            FLUSH: begin
                if (flush_ready_i) begin
                    state_next = mret_reg ? W_STATUS : W_EPC;
                end
            end
            W_EPC:    state_next = W_CAUSE;
            W_CAUSE:  state_next = W_TVAL;
            W_TVAL:   state_next = W_STATUS;
            W_STATUS: state_next = REDIRECT;
            REDIRECT: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // mstatus update and redirect target
    // -------------------------------------------------------------------------
    logic [Xlen-1:0] mstatus_new;
    logic [Xlen-1:0] trap_base;
    logic [Xlen-1:0] trap_target;

    always_comb begin
        mstatus_new = mstatus_i;
        if (mret_reg) begin
            mstatus_new[MS_MIE]  = mstatus_i[MS_MPIE];
            mstatus_new[MS_MPIE] = 1'b1;
        end else begin
            mstatus_new[MS_MPIE] = mstatus_i[MS_MIE];
            mstatus_new[MS_MIE]  = 1'b0;
        end
        // This hart has only M-mode, so the previous privilege is always M.
        mstatus_new[MS_MPP +: 2] = 2'b11;
    end

    assign trap_base = {mtvec_i[Xlen-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    always_comb begin
        trap_target = trap_base;
        if (cause_reg[Xlen-1] && (mtvec_i[1:0] == 2'b01)) begin
            trap_target = trap_base + {cause_reg[Xlen-3:0], 2'b00};
        end
    end
`else
    assign trap_target = trap_base;
`endif

    // Inputs that are only partly used by design. Folding them into one sink
    // keeps that visible in a single place.
    logic unused_inputs;
`ifdef TRAP_VECTORED_EN
    assign unused_inputs = ^{mip_i, mie_i};
`else
    assign unused_inputs = ^{mip_i, mie_i, mtvec_i[1:0]};
`endif

    // -------------------------------------------------------------------------
    // Outputs, decoded from the current state
    // -------------------------------------------------------------------------
    always_comb begin
        busy_o           = (state_reg != IDLE);
        flush_o          = (state_reg == FLUSH);
        csr_we_o         = 1'b0;
        csr_waddr_o      = '0;
        csr_wdata_o      = '0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;

        unique case (state_reg)
            W_EPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MEPC;
                csr_wdata_o = {pc_reg, 1'b0};
            end
            W_CAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MCAUSE;
                csr_wdata_o = cause_reg;
            end
            W_TVAL: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MTVAL;
                csr_wdata_o = tval_reg;
            end
            W_STATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = mstatus_new;
            end
            REDIRECT: begin
                redirect_valid_o = 1'b1;
                // For mret, mepc is read live so that it reflects the CSR file.
                redirect_pc_o    = mret_reg ? mepc_i : trap_target;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// -----------------------------------------------------------------------------
// tb_trap_sequencer
//
// Scoreboard bench for trap_sequencer.
//   - Each scenario task drives a request and pushes the CSR writes and the
//     redirect it expects, each tagged with the bench cycle at which it must
//     appear.
//   - A negedge monitor pops one entry per observed CSR write or redirect and
//     compares it.
//   - Scenario-specific state (busy/flush/reset outputs, drained queue) is
//     compared inline in each task.
// -----------------------------------------------------------------------------
module tb_trap_sequencer;

    localparam int XL = 64;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          exc_valid_i;
    logic [XL-1:0] exc_cause_i, exc_pc_i, exc_tval_i;
    logic          mret_valid_i;
    logic [XL-1:0] irq_pc_i, mip_i, mie_i, mstatus_i, mtvec_i, mepc_i;
    logic          flush_ready_i;
    logic          busy_o, flush_o, csr_we_o, redirect_valid_o;
    logic [11:0]   csr_waddr_o;
    logic [XL-1:0] csr_wdata_o, redirect_pc_o;

    trap_sequencer #(.Xlen(XL)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .exc_valid_i      (exc_valid_i),
        .exc_cause_i      (exc_cause_i),
        .exc_pc_i         (exc_pc_i),
        .exc_tval_i       (exc_tval_i),
        .mret_valid_i     (mret_valid_i),
        .irq_pc_i         (irq_pc_i),
        .mip_i            (mip_i),
        .mie_i            (mie_i),
        .mstatus_i        (mstatus_i),
        .mtvec_i          (mtvec_i),
        .mepc_i           (mepc_i),
        .flush_ready_i    (flush_ready_i),
        .busy_o           (busy_o),
        .flush_o          (flush_o),
        .csr_we_o         (csr_we_o),
        .csr_waddr_o      (csr_waddr_o),
        .csr_wdata_o      (csr_wdata_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o)
    );

    always #5 clk = ~clk;

    // Bench cycle counter: the number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit            redir;
        logic [11:0]   addr;
        logic [XL-1:0] data;
        int            at;
    } exp_t;

    exp_t sb[$];

    // Request driven at bench cycle c is accepted on edge c+1. The trap writes
    // then appear at c+2..c+5 and the redirect at c+6.
    task automatic push_trap(input int c, input logic [XL-1:0] pc,
                             input logic [XL-1:0] cause, input logic [XL-1:0] tval,
                             input logic [XL-1:0] ms, input logic [XL-1:0] target);
        sb.push_back('{1'b0, A_MEPC,    {pc[XL-1:1], 1'b0}, c + 2});
        sb.push_back('{1'b0, A_MCAUSE,  cause,              c + 3});
        sb.push_back('{1'b0, A_MTVAL,   tval,               c + 4});
        sb.push_back('{1'b0, A_MSTATUS, ms,                 c + 5});
        sb.push_back('{1'b1, 12'h000,   target,             c + 6});
    endtask

    task automatic push_mret(input int c, input logic [XL-1:0] ms,
                             input logic [XL-1:0] target);
        sb.push_back('{1'b0, A_MSTATUS, ms,     c + 2});
        sb.push_back('{1'b1, 12'h000,   target, c + 3});
    endtask

    // Monitor: every CSR write or redirect must match the next scoreboard entry.
    exp_t          mon_e;
    logic [11:0]   mon_addr;
    logic [XL-1:0] mon_data;
    always @(negedge clk) begin
        if (csr_we_o === 1'b1 || redirect_valid_o === 1'b1) begin
            mon_addr = redirect_valid_o ? 12'h000 : csr_waddr_o;
            mon_data = redirect_valid_o ? redirect_pc_o : csr_wdata_o;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected cyc=%0d got redir=%b addr=%h data=%h, required no event",
                         cyc, redirect_valid_o, mon_addr, mon_data);
            end else begin
                mon_e = sb.pop_front();
                if (redirect_valid_o !== mon_e.redir || csr_we_o === redirect_valid_o ||
                    mon_addr !== mon_e.addr || mon_data !== mon_e.data || cyc != mon_e.at) begin
                    n_bad++;
                    $display("FAIL sb_event got redir=%b addr=%h data=%h at cyc %0d, required redir=%b addr=%h data=%h at cyc %0d",
                             redirect_valid_o, mon_addr, mon_data, cyc,
                             mon_e.redir, mon_e.addr, mon_e.data, mon_e.at);
                end
            end
        end
        if (csr_we_o === 1'b0) begin
            n_cmp++;
            if (csr_waddr_o !== 12'h0 || csr_wdata_o !== '0) begin
                n_bad++;
                $display("FAIL idle_csr_bus cyc=%0d got addr=%h data=%h, required 0",
                         cyc, csr_waddr_o, csr_wdata_o);
            end
        end
        if (redirect_valid_o === 1'b0) begin
            n_cmp++;
            if (redirect_pc_o !== '0) begin
                n_bad++;
                $display("FAIL idle_redirect_pc cyc=%0d got %h, required 0", cyc, redirect_pc_o);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for the scoreboard to empty and the sequencer to go idle.
    // Returns the number of expected events still outstanding.
    task automatic drain(output int left);
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0 && busy_o === 1'b0) break;
            step();
        end
        left = sb.size();
        if (busy_o !== 1'b0) left = left + 1000;
    endtask

    task automatic clear_inputs();
        exc_valid_i   = 1'b0;
        exc_cause_i   = '0;
        exc_pc_i      = '0;
        exc_tval_i    = '0;
        mret_valid_i  = 1'b0;
        irq_pc_i      = '0;
        mip_i         = '0;
        mie_i         = '0;
        mstatus_i     = '0;
        mtvec_i       = '0;
        mepc_i        = '0;
        flush_ready_i = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst_i = 1'b1;
        clear_inputs();
        repeat (3) step();
        n_cmp++;
        if ({busy_o, flush_o, csr_we_o, redirect_valid_o} !== 4'b0000 ||
            csr_waddr_o !== 12'h0 || csr_wdata_o !== '0 || redirect_pc_o !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got busy=%b flush=%b we=%b redir=%b addr=%h data=%h pc=%h, required all 0",
                     busy_o, flush_o, csr_we_o, redirect_valid_o, csr_waddr_o, csr_wdata_o, redirect_pc_o);
        end
        rst_i = 1'b0;
        step();
    endtask

    // Illegal instruction trap with pass-through bits in mstatus.
    task automatic test_exception();
        int left;
        mtvec_i       = 64'h8000_1000;
        mstatus_i     = 64'h0000_000A_0000_200A;
        flush_ready_i = 1'b1;
        exc_valid_i   = 1'b1;
        exc_cause_i   = 64'd2;
        exc_pc_i      = 64'h8000_0010;
        exc_tval_i    = 64'h13;
        push_trap(cyc, 64'h8000_0010, 64'd2, 64'h13, 64'h0000_000A_0000_3882, 64'h8000_1000);
        step();
        exc_valid_i = 1'b0;
        n_cmp++;
        if (busy_o !== 1'b1 || flush_o !== 1'b1) begin
            n_bad++;
            $display("FAIL exc_accept got busy=%b flush=%b, required 1 1", busy_o, flush_o);
        end
        drain(left);
        n_cmp++;
        if (left !== 0) begin
            n_bad++;
            $display("FAIL exc_drain got %0d outstanding, required 0", left);
        end
    endtask

    // Interrupt with mixed pending lines, plus a priority sweep.
    localparam logic [15:0] PR_MIP  [8] = '{16'h2888, 16'h2288, 16'h2282, 16'h2222,
                                            16'h2022, 16'h2020, 16'h2000, 16'h0888};
    localparam logic [15:0] PR_MIE  [8] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                                            16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0080};
    localparam int          PR_CODE [8] = '{11, 3, 7, 9, 1, 5, 13, 7};

    task automatic test_interrupt();
        int left;
        logic [XL-1:0] tgt;
        logic [XL-1:0] cause;
        mtvec_i   = 64'h8000_1001;
        mstatus_i = 64'h8;
        for (int i = 0; i < 9; i++) begin
            if (i == 0) begin
                mip_i = 64'h888;
                mie_i = 64'h888;
                cause = 64'h8000_0000_0000_000B;
            end else begin
                mip_i = {48'h0, PR_MIP[i-1]};
                mie_i = {48'h0, PR_MIE[i-1]};
                cause = {1'b1, 63'(PR_CODE[i-1])};
            end
            irq_pc_i = 64'h8000_0200 + 64'(i * 16);
`ifdef TRAP_VECTORED_EN
            tgt = 64'h8000_1000 + {cause[XL-3:0], 2'b00};
`else
            tgt = 64'h8000_1000;
`endif
            push_trap(cyc, irq_pc_i, cause, 64'h0, 64'h1880, tgt);
            step();
            mip_i = '0;
            drain(left);
            n_cmp++;
            if (left !== 0) begin
                n_bad++;
                $display("FAIL irq_drain case %0d got %0d outstanding, required 0", i, left);
            end
        end
        mie_i = '0;
    endtask

    // mret, with mepc changed after acceptance so that it is read in REDIRECT.
    task automatic test_mret();
        int left;
        mstatus_i    = 64'h82;
        mepc_i       = 64'hDEAD_BEE0;
        mret_valid_i = 1'b1;
        push_mret(cyc, 64'h188A, 64'h8000_0040);
        step();
        mret_valid_i = 1'b0;
        mepc_i       = 64'h8000_0040;
        drain(left);
        n_cmp++;
        if (left !== 0) begin
            n_bad++;
            $display("FAIL mret_drain got %0d outstanding, required 0", left);
        end
    endtask

    // Exception and mret together with an interrupt pending.
    task automatic test_simultaneous();
        int left;
        int c;
        mtvec_i      = 64'h8000_1000;
        mstatus_i    = 64'h8;
        mip_i        = 64'h80;
        mie_i        = 64'h80;
        irq_pc_i     = 64'h8000_0700;
        exc_valid_i  = 1'b1;
        mret_valid_i = 1'b1;
        exc_cause_i  = 64'd5;
        exc_pc_i     = 64'h8000_0300;
        exc_tval_i   = 64'hABC;
        c = cyc;
        push_trap(c, 64'h8000_0300, 64'd5, 64'hABC, 64'h1880, 64'h8000_1000);
        // The interrupt is accepted on the edge after the IDLE cycle that
        // follows REDIRECT.
        push_trap(c + 7, 64'h8000_0700, {1'b1, 63'd7}, 64'h0, 64'h1880, 64'h8000_1000);
        step();
        exc_valid_i  = 1'b0;
        mret_valid_i = 1'b0;
        while (cyc < c + 8) step();
        mip_i = '0;
        drain(left);
        n_cmp++;
        if (left !== 0) begin
            n_bad++;
            $display("FAIL simul_mie1_drain got %0d outstanding, required 0", left);
        end

        // The same request with mstatus.mie=0: the interrupt must stay pending.
        mstatus_i    = 64'h0;
        mip_i        = 64'h80;
        exc_valid_i  = 1'b1;
        mret_valid_i = 1'b1;
        push_trap(cyc, 64'h8000_0300, 64'd5, 64'hABC, 64'h1800, 64'h8000_1000);
        step();
        exc_valid_i  = 1'b0;
        mret_valid_i = 1'b0;
        drain(left);
        repeat (5) step();
        n_cmp++;
        if (left !== 0 || busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL simul_mie0 got outstanding=%0d busy=%b, required 0 0", left, busy_o);
        end
        mip_i = '0;
        mie_i = '0;
    endtask

    // Pipeline not drained for 5 cycles.
    task automatic test_flush_stall();
        int left;
        mtvec_i       = 64'h8000_2000;
        mstatus_i     = 64'h8;
        flush_ready_i = 1'b0;
        exc_valid_i   = 1'b1;
        exc_cause_i   = 64'd4;
        exc_pc_i      = 64'h8000_0404;
        exc_tval_i    = 64'h1001;
        step();
        exc_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (flush_o !== 1'b1 || busy_o !== 1'b1) begin
                n_bad++;
                $display("FAIL stall_hold cycle %0d got flush=%b busy=%b, required 1 1", i, flush_o, busy_o);
            end
            step();
        end
        flush_ready_i = 1'b1;
        push_trap(cyc - 1, 64'h8000_0404, 64'd4, 64'h1001, 64'h1880, 64'h8000_2000);
        drain(left);
        n_cmp++;
        if (left !== 0) begin
            n_bad++;
            $display("FAIL stall_drain got %0d outstanding, required 0", left);
        end
    endtask

    // Reset asserted while mcause is being written.
    task automatic test_reset_mid();
        int left;
        mtvec_i     = 64'h8000_3000;
        mstatus_i   = 64'h8;
        exc_valid_i = 1'b1;
        exc_cause_i = 64'd7;
        exc_pc_i    = 64'h8000_0800;
        exc_tval_i  = 64'h55;
        push_trap(cyc, 64'h8000_0800, 64'd7, 64'h55, 64'h1880, 64'h8000_3000);
        repeat (3) void'(sb.pop_back());
        step();
        exc_valid_i = 1'b0;
        step();
        step();
        n_cmp++;
        if (csr_waddr_o !== A_MCAUSE) begin
            n_bad++;
            $display("FAIL rstmid_state got addr=%h, required %h", csr_waddr_o, A_MCAUSE);
        end
        rst_i = 1'b1;
        step();
        n_cmp++;
        if ({busy_o, flush_o, csr_we_o, redirect_valid_o} !== 4'b0000 ||
            csr_waddr_o !== 12'h0 || csr_wdata_o !== '0 || redirect_pc_o !== '0) begin
            n_bad++;
            $display("FAIL rstmid_outputs got busy=%b flush=%b we=%b redir=%b, required all 0",
                     busy_o, flush_o, csr_we_o, redirect_valid_o);
        end
        rst_i = 1'b0;
        repeat (8) step();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL rstmid_drain got %0d outstanding, required 0", sb.size());
        end
        // A fresh exception runs normally. Its odd pc is halfword aligned in mepc.
        exc_valid_i = 1'b1;
        exc_cause_i = 64'd3;
        exc_pc_i    = 64'h8000_0101;
        exc_tval_i  = 64'h0;
        push_trap(cyc, 64'h8000_0100, 64'd3, 64'h0, 64'h1880, 64'h8000_3000);
        step();
        exc_valid_i = 1'b0;
        drain(left);
        n_cmp++;
        if (left !== 0) begin
            n_bad++;
            $display("FAIL rstmid_after got %0d outstanding, required 0", left);
        end
    endtask

    // mret held during a trap sequence is taken right after it returns to IDLE.
    task automatic test_back_to_back();
        int left;
        int c;
        mtvec_i     = 64'h8000_4000;
        mstatus_i   = 64'h8;
        mepc_i      = 64'h8000_0500;
        exc_valid_i = 1'b1;
        exc_cause_i = 64'd11;
        exc_pc_i    = 64'h8000_0900;
        exc_tval_i  = 64'h0;
        c = cyc;
        push_trap(c, 64'h8000_0900, 64'd11, 64'h0, 64'h1880, 64'h8000_4000);
        push_mret(c + 7, 64'h1880, 64'h8000_0500);
        step();
        exc_valid_i  = 1'b0;
        mret_valid_i = 1'b1;
        while (cyc < c + 8) step();
        mret_valid_i = 1'b0;
        drain(left);
        n_cmp++;
        if (left !== 0) begin
            n_bad++;
            $display("FAIL b2b_drain got %0d outstanding, required 0", left);
        end
    endtask

    initial begin
        test_reset();
        test_exception();
        test_interrupt();
        test_mret();
        test_simultaneous();
        test_flush_stall();
        test_reset_mid();
        test_back_to_back();
        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
